// File: rtl/vote_pkg.sv
// Shared types and constants for the 5-voter ballot collector.
// No logic; the state enum and widths are used by the collector and its popcount.
package vote_pkg;

   localparam int N_VOTERS   = 5;
   localparam int TALLY_W    = 3;
   localparam int MAJ_THRESH = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

endpackage

// File: rtl/vote_popcount5.sv
// Combinational 5-bit popcount with majority flag; zero latency.
// No handshake; the output follows the input in the same cycle.
module vote_popcount5
   import vote_pkg::*;
(
   input  logic [N_VOTERS-1:0] votes,
   output logic [TALLY_W-1:0]  tally,
   output logic                majority
);

   always_comb begin
      tally = '0;
      for (int i = 0; i < N_VOTERS; i++) begin
         tally = tally + TALLY_W'(votes[i]);
      end
      majority = (tally >= TALLY_W'(MAJ_THRESH));
   end

endmodule

// File: rtl/vote_collector.sv
// Collects one vote per voter per ballot; result_valid 1 cycle after the last accept or timeout.
// Each voter is held off (ready low) once accepted; start is honoured only in IDLE.
module vote_collector
   import vote_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_bit,
   output logic [N_VOTERS-1:0] vote_ready,
   output logic                busy,
   output logic                result_valid,
   output logic [N_VOTERS-1:0] ballot,
   output logic [N_VOTERS-1:0] voted_mask,
   output logic [TALLY_W-1:0]  tally,
   output logic                majority,
   output logic                timed_out
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q;
   logic [N_VOTERS-1:0] accept;
   logic [N_VOTERS-1:0] mask_col;
   logic [N_VOTERS-1:0] ballot_d;
   logic [TALLY_W-1:0]  tally_d;
   logic                maj_d;
   logic                all_in;
   logic                last_cycle;

   assign accept     = vote_valid & vote_ready;
   assign mask_col   = voted_mask | accept;
   assign all_in     = &mask_col;
   assign last_cycle = (timer_q == TMR_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A vote landing in the final cycle completes the ballot, so all_in wins over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (all_in || last_cycle) state_d = REPORT;
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vote_ready   = '0;
      busy         = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         COLLECT: begin
            vote_ready = ~voted_mask;
            busy       = 1'b1;
         end
         REPORT: begin
            busy         = 1'b1;
            result_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Popcount runs on the next ballot so tally/majority register alongside it.
   always_comb begin
      ballot_d = ballot;
      if (state_q == IDLE && start) begin
         ballot_d = '0;
      end else if (state_q == COLLECT) begin
         ballot_d = (ballot & ~accept) | (vote_bit & accept);
      end
   end

   vote_popcount5 u_popcount (
      .votes    (ballot_d),
      .tally    (tally_d),
      .majority (maj_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ballot     <= '0;
         voted_mask <= '0;
         tally      <= '0;
         majority   <= 1'b0;
         timed_out  <= 1'b0;
         timer_q    <= '0;
      end else begin
         ballot   <= ballot_d;
         tally    <= tally_d;
         majority <= maj_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  voted_mask <= '0;
                  timed_out  <= 1'b0;
                  timer_q    <= TMR_W'(TIMEOUT_CYCLES);
               end
            end
            COLLECT: begin
               voted_mask <= mask_col;
               timer_q    <= timer_q - TMR_W'(1);
               timed_out  <= !all_in && last_cycle;
            end
            default: ;
         endcase
      end
   end

endmodule
